// File: rtl/stage_fetch1_pkg.sv
// Shared types for the second fetch stage: FSM encoding and field widths.
package stage_fetch1_pkg;

  localparam int PC_W   = 30;
  localparam int INSN_W = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    FULL  = 2'd2,
    DROP  = 2'd3
  } fe1_state_t;

  // A faulting fetch0 request never reaches the cache, so it lands directly in the buffer.
  function automatic fe1_state_t take_target(input logic exc);
    return exc ? FULL : WAIT;
  endfunction

endpackage

// File: rtl/stage_fetch1_if.sv
// Fetch0 request, instruction-cache response and decode-side signals of fetch1.
interface stage_fetch1_if;
  import stage_fetch1_pkg::*;

  logic              fe0_valid;
  logic [PC_W-1:0]   fe0_pc;
  logic              fe0_exc;
  logic              fe1_stall;
  logic              ic_resp_valid;
  logic [INSN_W-1:0] ic_resp_data;
  logic              ic_resp_fault;
  logic              de_setpc;
  logic              csr_kill;
  logic              de_stall;
  logic              fe1_valid;
  logic              fe1_exc;
  logic [PC_W-1:0]   fe1_pc;
  logic [INSN_W-1:0] fe1_insn;

  modport master (
    output fe0_valid, fe0_pc, fe0_exc,
    output ic_resp_valid, ic_resp_data, ic_resp_fault,
    output de_setpc, csr_kill, de_stall,
    input  fe1_stall, fe1_valid, fe1_exc, fe1_pc, fe1_insn
  );

  modport slave (
    input  fe0_valid, fe0_pc, fe0_exc,
    input  ic_resp_valid, ic_resp_data, ic_resp_fault,
    input  de_setpc, csr_kill, de_stall,
    output fe1_stall, fe1_valid, fe1_exc, fe1_pc, fe1_insn
  );
endinterface

// File: rtl/stage_fetch1.sv
// Second fetch stage: tracks the one outstanding cache request, bypasses or buffers the
// response for decode, and discards wrong-path responses after a redirect or kill.
module stage_fetch1
  import stage_fetch1_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk_core,
  input  logic           reset_n,
  stage_fetch1_if.slave  bus
);

  fe1_state_t        state_p1, state_d;
  logic [PC_W-1:0]   pc_p1;
  logic [INSN_W-1:0] insn_p1;
  logic              fault_p1;

  logic              kill, in_wait, in_full, in_drop;
  logic              present, fault_sel, stall, take, capture;
  logic [INSN_W-1:0] insn_sel;

  assign kill    = bus.de_setpc | bus.csr_kill;
  assign in_wait = (state_p1 == WAIT);
  assign in_full = (state_p1 == FULL);
  assign in_drop = (state_p1 == DROP);

  assign present   = (in_wait & bus.ic_resp_valid) | in_full;
  assign fault_sel = in_full ? fault_p1 : bus.ic_resp_fault;
  assign insn_sel  = in_full ? insn_p1  : bus.ic_resp_data;

  assign stall = kill
               | (in_wait & ~bus.ic_resp_valid)
               | (present & bus.de_stall)
               | (in_drop & ~bus.ic_resp_valid);

  assign take    = bus.fe0_valid & ~stall;
  assign capture = in_wait & bus.ic_resp_valid & bus.de_stall & ~kill;

  assign bus.fe1_stall = stall;
  assign bus.fe1_valid = present & ~fault_sel & ~kill;
  assign bus.fe1_exc   = present &  fault_sel & ~kill;
  assign bus.fe1_pc    = pc_p1;
  assign bus.fe1_insn  = (present & ~fault_sel & ~kill) ? insn_sel : '0;

  always_comb begin
    state_d = state_p1;
    if (kill) begin
      // An unanswered request must have its response swallowed later; anything else is dropped now.
      unique case (state_p1)
        WAIT:    state_d = bus.ic_resp_valid ? EMPTY : DROP;
        DROP:    state_d = bus.ic_resp_valid ? EMPTY : DROP;
        default: state_d = EMPTY;
      endcase
    end else begin
      unique case (state_p1)
        EMPTY: if (take) state_d = take_target(bus.fe0_exc);
        WAIT: begin
          if (bus.ic_resp_valid) begin
            if (bus.de_stall)  state_d = FULL;
            else if (take)     state_d = take_target(bus.fe0_exc);
            else               state_d = EMPTY;
          end
        end
        FULL: begin
          if (!bus.de_stall) state_d = take ? take_target(bus.fe0_exc) : EMPTY;
        end
        DROP: begin
          if (bus.ic_resp_valid) state_d = take ? take_target(bus.fe0_exc) : EMPTY;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // ---- stage p1: request tracking and single-entry buffer ----
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      state_p1 <= EMPTY;
      pc_p1    <= RESET_PC[31:2];
      insn_p1  <= '0;
      fault_p1 <= 1'b0;
    end else begin
      state_p1 <= state_d;
      if (take) pc_p1 <= bus.fe0_pc;
      if (take && bus.fe0_exc) begin
        insn_p1  <= '0;
        fault_p1 <= 1'b1;
      end else if (capture) begin
        insn_p1  <= bus.ic_resp_data;
        fault_p1 <= bus.ic_resp_fault;
      end
    end
  end

endmodule

// File: doc/stage_fetch1.md
Name: stage_fetch1

Overview:
- Second fetch stage. Tracks the single outstanding instruction-cache request issued by fetch0.
- Receives the cache response and presents the instruction word, PC and fetch-fault flag to decode.
- Buffers one instruction while decode stalls, and discards wrong-path responses after a redirect or kill.
- Full throughput is 1 instruction/cycle when the cache responds in 1 cycle.

Parameters:
RESET_PC, 32'h0000_0000, value driven on fe1_pc during reset; bits [1:0] ignored.

Ports:
clk_core  in  1  core clock
reset_n  in  1  synchronous active-low reset
fe0_valid  in  1  fetch0 presents a new request this cycle (cache request issued unless fe0_exc)
fe0_pc  in  30  PC[31:2] of the fetch0 request
fe0_exc  in  1  fetch0 fault on this PC; no cache request was issued
fe1_stall  out  1  fetch0 must hold its request and not issue another
ic_resp_valid  in  1  instruction-cache response for the outstanding request
ic_resp_data  in  32  instruction word
ic_resp_fault  in  1  access fault on the outstanding request
de_setpc  in  1  decode/execute redirect; current fetch1 contents are wrong-path
csr_kill  in  1  trap/exception kill
de_stall  in  1  decode cannot accept this cycle
fe1_valid  out  1  valid instruction presented to decode
fe1_exc  out  1  fetch fault presented to decode (mutually exclusive with fe1_valid)
fe1_pc  out  30  PC[31:2] of the presented entry
fe1_insn  out  32  instruction word (0 when fe1_exc)

Behaviour:
- kill = de_setpc | csr_kill. fetch0 never asserts fe0_valid in a kill cycle (contract). fe1 ignores fe0_valid in kill cycles anyway, and the bench asserts this.
- State enum fe1_state_t: EMPTY, WAIT, FULL, DROP. Reset: EMPTY, fe1_pc=RESET_PC[31:2], buffer cleared; all outputs 0 except fe1_pc. Reset mid-WAIT goes to EMPTY; the cache is reset on the same reset_n, so no stale response arrives.
- present = (WAIT & ic_resp_valid) | FULL.
- Output source: in WAIT the outputs bypass directly from the cache response (ic_resp_data/ic_resp_fault). In FULL they come from the registered buffer.
- fe1_valid = present & ~fault & ~kill. fe1_exc = present & fault & ~kill. fe1_pc = held PC register.
- accept = present & ~de_stall & ~kill.
- fe1_stall = kill | (WAIT & ~ic_resp_valid) | (present & de_stall) | (DROP & ~ic_resp_valid).
- take = fe0_valid & ~fe1_stall. On take: latch fe0_pc. If fe0_exc, next state is FULL with fault=1, insn=0. Otherwise next state is WAIT.
- EMPTY: take moves to WAIT or FULL as above; otherwise stay EMPTY.
- WAIT, no response: stay WAIT.
- WAIT, response: if ~de_stall, the entry is consumed this cycle, then take or go to EMPTY. If de_stall, capture data and fault into the buffer and go to FULL.
- FULL: hold while de_stall. When ~de_stall, the entry is consumed, then take or go to EMPTY.
- DROP: discard the first ic_resp_valid (never presented). In that same cycle fe1_stall=0, so take is allowed and the new request moves to WAIT/FULL. Otherwise stay DROP.
- Kill has priority over all of the above:
  - WAIT without a response in the same cycle goes to DROP.
  - WAIT with a response, FULL, or EMPTY goes to EMPTY; the response is dropped.
  - DROP stays DROP unless a response arrives, in which case it goes to EMPTY.
- At most one cache request is outstanding at any time. fe1_stall guarantees fetch0 never issues while WAIT/DROP is unresolved.
- ic_resp_valid in EMPTY or FULL is a protocol error (bench assertion; RTL ignores it).
- fe1_pc and fe1_insn are stable while fe1_stall & present.

Decomposition:
- Add fe1_state_t to defines.svh alongside the existing enums.
- No sub-module. The single-entry buffer and FSM stay in stage_fetch1.

Test Plan:
- Streaming: fe0_valid every cycle with PCs 0x100,0x104,0x108; 1-cycle cache responses; de_stall=0 -> fe1_valid high every cycle after the first, fe1_pc tracks each PC with 1-cycle lag, fe1_stall=0 throughout.
- Decode stall: de_stall=1 for 3 cycles while response 0x00500093 arrives for PC 0x200 -> FULL; fe1_insn holds 0x00500093, fe1_stall=1, no new take. Entry consumed on the first ~de_stall cycle.
- Slow cache: response 4 cycles after take -> fe1_stall=1 and fe1_valid=0 for 3 cycles; the instruction is presented in the response cycle via bypass.
- Kill in WAIT: de_setpc while waiting on PC 0x300; stale response 2 cycles later -> state DROP, stale word never presented. The new request to 0x400 is taken in the discard cycle and its instruction is presented next.
- Faults: fe0_exc on take of PC 0x500 -> fe1_exc=1, fe1_valid=0, fe1_insn=0 the next cycle. ic_resp_fault on PC 0x504 -> fe1_exc=1 in the response cycle.
- Reset mid-FULL with de_stall=1 -> next cycle EMPTY, fe1_valid=fe1_exc=fe1_stall=0, fe1_pc=RESET_PC[31:2].
